// File: rtl/zone_scan_ctrl.sv
// zone_scan_ctrl
//   Ping-pong buffered backlight zone scanner. The mapper writes zone words
//   into the write bank; a refresh pulse swaps banks and the scan bank is
//   shifted out MSB first to a serial LED driver chain, zone 0 first,
//   followed by a latch pulse.
//
// Ports
//   sys_clk        single clock, rising edge
//   sys_rst        synchronous active-high reset; also starts a bank clear
//   light          zone brightness word
//   light_index    zone address for light (>= ZONES is ignored)
//   light_wr       write strobe for light/light_index
//   light_refresh  frame-complete pulse; starts a scan when idle
//   drv_sclk       serial clock to the driver chain
//   drv_sdo        serial data, MSB first
//   drv_lat        latch pulse, LAT_CYC cycles
//   busy           high during a scan or the post-reset bank clear
//   overrun        one-cycle pulse when a refresh is dropped
module zone_scan_ctrl #(
    parameter int ZONES   = 384,
    parameter int DW      = 16,
    parameter int CLK_DIV = 2,
    parameter int LAT_CYC = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [DW-1:0] light,
    input  logic [8:0]    light_index,
    input  logic          light_wr,
    input  logic          light_refresh,
    output logic          drv_sclk,
    output logic          drv_sdo,
    output logic          drv_lat,
    output logic          busy,
    output logic          overrun
);

    localparam int AW = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LW = (LAT_CYC > 1) ? $clog2(LAT_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DW-1:0] bank0 [ZONES];
    logic [DW-1:0] bank1 [ZONES];

    logic          wr_bank;    // bank the mapper writes; the other one is scanned
    logic          clearing;
    logic [AW-1:0] clr_idx;
    logic [AW-1:0] zone_cnt;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] div_cnt;
    logic          sclk_hi;    // current half of the bit period
    logic [LW-1:0] lat_cnt;
    logic [DW-1:0] shreg;

    logic          clr_active;
    logic          idx_ok;
    logic          wr_en;
    logic          refresh_ok;
    logic          div_end;
    logic          bit_end;
    logic          zone_end;
    logic          last_zone;
    logic          lat_end;
    logic [DW-1:0] scan_word;
    logic [AW-1:0] wr_addr;

    // The clear only runs once reset is released, so busy stays low during reset.
    assign clr_active = clearing & ~sys_rst;
    assign idx_ok     = ({1'b0, light_index} < 10'(ZONES));
    assign wr_en      = light_wr & idx_ok & ~clearing & ~sys_rst;
    assign wr_addr    = light_index[AW-1:0];
    assign refresh_ok = light_refresh & (state == IDLE) & ~clearing;
    assign div_end    = (div_cnt == CW'(CLK_DIV - 1));
    assign bit_end    = sclk_hi & div_end;
    assign zone_end   = bit_end & (bit_cnt == BW'(DW - 1));
    assign last_zone  = (zone_cnt == AW'(ZONES - 1));
    assign lat_end    = (lat_cnt == LW'(LAT_CYC - 1));
    assign scan_word  = wr_bank ? bank0[zone_cnt] : bank1[zone_cnt];

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (refresh_ok) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (zone_end) state_nxt = last_zone ? LATCH : LOAD;
            LATCH:   if (lat_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; gated by reset so an aborted scan goes quiet immediately
    always_comb begin
        busy     = ((state != IDLE) | clr_active) & ~sys_rst;
        drv_sclk = (state == SHIFT) & sclk_hi & ~sys_rst;
        drv_sdo  = (state == SHIFT) & shreg[DW-1] & ~sys_rst;
        drv_lat  = (state == LATCH) & ~sys_rst;
    end

    // Control counters, bank select, clear sequencer and overrun flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_bank  <= 1'b0;
            clearing <= 1'b1;
            clr_idx  <= '0;
            zone_cnt <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            sclk_hi  <= 1'b0;
            lat_cnt  <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= light_refresh & ~refresh_ok;
            if (clearing) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_idx == AW'(ZONES - 1)) clearing <= 1'b0;
            end
            if (refresh_ok) wr_bank <= ~wr_bank;
            case (state)
                IDLE: begin
                    zone_cnt <= '0;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    sclk_hi  <= 1'b0;
                    lat_cnt  <= '0;
                end
                LOAD: begin
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    sclk_hi <= 1'b0;
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk_hi <= ~sclk_hi;
                        if (zone_end) begin
                            bit_cnt <= '0;
                            if (!last_zone) zone_cnt <= zone_cnt + 1'b1;
                        end else if (bit_end) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: lat_cnt <= lat_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Shift register: loaded in LOAD, advanced at the end of each high half so
    // drv_sdo only changes at the start of a low half.
    always_ff @(posedge sys_clk) begin
        if (state == LOAD) begin
            shreg <= scan_word;
        end else if (state == SHIFT && bit_end) begin
            shreg <= shreg << 1;
        end
    end

    // Bank storage; the clear writes both banks at once
    always_ff @(posedge sys_clk) begin
        if (clr_active) begin
            bank0[clr_idx] <= '0;
            bank1[clr_idx] <= '0;
        end else if (wr_en) begin
            if (wr_bank) begin
                bank1[wr_addr] <= light;
            end else begin
                bank0[wr_addr] <= light;
            end
        end
    end

endmodule
